// File: rtl/microwave_timer.sv
// BCD mm:ss countdown timer for the microwave controller: keypad shift-in entry, 1 Hz countdown gated by mag_on.
// Optional 30-second quick-add is compiled in with `define MICROWAVE_TIMER_ADD30_EN.
module microwave_timer #(
    parameter int TICKS_PER_SEC = 100
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clrn_i,
    input  logic       key_valid_i,
    input  logic [3:0] key_digit_i,
    input  logic       add30_i,
    input  logic       mag_on_i,
    output logic [3:0] min_tens_o,
    output logic [3:0] min_ones_o,
    output logic [3:0] sec_tens_o,
    output logic [3:0] sec_ones_o,
    output logic       timer_done_o,
    output logic       done_pulse_o,
    output logic       running_o
);

    // state | meaning
    // IDLE  | accepting keypad digits, prescaler cleared
    // RUN   | counting down once per TICKS_PER_SEC cycles
    // PAUSE | mag_on dropped mid-run, count and prescaler frozen
    // DONE  | reached 00:00, waiting for new entry or mag_on release
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          pulse_q, pulse_d;

    logic          tick;
    logic          key_ok;
    logic          add_ok;
    logic [15:0]   cnt_dec;
    logic [15:0]   cnt_base;
    logic [15:0]   cnt_add;

    function automatic logic [15:0] bcd_dec(input logic [15:0] c);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = c;
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else begin
                    mo = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

`ifdef MICROWAVE_TIMER_ADD30_EN
    function automatic logic [15:0] bcd_add30(input logic [15:0] c);
        logic [3:0] mt, mo, st, so;
        logic       sat;
        {mt, mo, st, so} = c;
        sat = 1'b0;
        if (st >= 4'd3) begin
            st = st - 4'd3;
            if (mo != 4'd9) begin
                mo = mo + 4'd1;
            end else begin
                mo = 4'd0;
                if (mt != 4'd9) mt = mt + 4'd1;
                else            sat = 1'b1;
            end
        end else begin
            st = st + 4'd3;
        end
        return sat ? 16'h9959 : {mt, mo, st, so};
    endfunction
`endif

    assign tick     = (state_q == RUN) && (presc_q == PRESC_MAX);
    assign key_ok   = key_valid_i && (key_digit_i <= 4'd9);
    assign cnt_dec  = bcd_dec(cnt_q);
    // A tick and a quick-add on the same cycle: decrement first, then add.
    assign cnt_base = tick ? cnt_dec : cnt_q;

`ifdef MICROWAVE_TIMER_ADD30_EN
    assign add_ok  = add30_i;
    assign cnt_add = bcd_add30(cnt_base);
`else
    logic unused_add30;
    assign unused_add30 = add30_i;
    assign add_ok       = 1'b0;
    assign cnt_add      = cnt_base;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        presc_d = presc_q;
        pulse_d = 1'b0;

        if (!clrn_i) begin
            state_d = IDLE;
            cnt_d   = 16'h0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (add_ok)      cnt_d = cnt_add;
                    else if (key_ok) cnt_d = {cnt_q[11:0], key_digit_i};
                    if (mag_on_i && (cnt_q != 16'h0000)) state_d = RUN;
                end
                RUN: begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    cnt_d   = add_ok ? cnt_add : cnt_base;
                    if (tick && (cnt_q == 16'h0001) && !add_ok) begin
                        state_d = DONE;
                        pulse_d = 1'b1;
                    end else if (!mag_on_i) begin
                        state_d = PAUSE;
                    end
                end
                PAUSE: begin
                    if (add_ok) cnt_d = cnt_add;
                    if (mag_on_i) state_d = RUN;
                end
                DONE: begin
                    if (add_ok) begin
                        cnt_d   = 16'h0030;
                        state_d = IDLE;
                    end else if (key_ok) begin
                        cnt_d   = {12'h000, key_digit_i};
                        state_d = IDLE;
                    end else if (!mag_on_i) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (state_d == IDLE) presc_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 16'h0000;
            presc_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            pulse_q <= pulse_d;
        end
    end

    assign {min_tens_o, min_ones_o, sec_tens_o, sec_ones_o} = cnt_q;
    assign timer_done_o = (cnt_q == 16'h0000);
    assign done_pulse_o = pulse_q;
    assign running_o    = (state_q == RUN);

endmodule

// File: tb/tb_microwave_timer.sv
// Scoreboard bench for microwave_timer with TICKS_PER_SEC=4; expected display/flags are queued per cycle.
module tb_microwave_timer;

    localparam int TPS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clrn = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       add30 = 1'b0;
    logic       mag_on = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       timer_done, done_pulse, running;
    logic [15:0] obs;

    int errors = 0;
    int checks = 0;
    int pulse_cnt = 0;

    typedef struct {
        int          cyc;
        string       name;
        logic [15:0] cnt;
        logic        done;
        logic        run;
        logic        pulse;
    } exp_t;

    exp_t sb[$];

    microwave_timer #(.TICKS_PER_SEC(TPS)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .clrn_i       (clrn),
        .key_valid_i  (key_valid),
        .key_digit_i  (key_digit),
        .add30_i      (add30),
        .mag_on_i     (mag_on),
        .min_tens_o   (min_tens),
        .min_ones_o   (min_ones),
        .sec_tens_o   (sec_tens),
        .sec_ones_o   (sec_ones),
        .timer_done_o (timer_done),
        .done_pulse_o (done_pulse),
        .running_o    (running)
    );

    assign obs = {min_tens, min_ones, sec_tens, sec_ones};

    always #5 clk = ~clk;

    always @(negedge clk) if (done_pulse === 1'b1) pulse_cnt++;

    function automatic exp_t mk(input int cyc, input string name, input logic [15:0] cnt,
                                input logic run, input logic pulse);
        exp_t e;
        e.cyc   = cyc;
        e.name  = name;
        e.cnt   = cnt;
        e.done  = (cnt == 16'h0000);
        e.run   = run;
        e.pulse = pulse;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        step();
        key_valid = 1'b0;
        key_digit = 4'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t x;
        rst = 1'b1; key_valid = 1'b1; key_digit = 4'd5; mag_on = 1'b1;
        step(); step();
        sb.push_back(mk(0, "reset", 16'h0000, 1'b0, 1'b0));
        x = sb.pop_front(); checks++;
        if (obs !== x.cnt || timer_done !== x.done || running !== x.run || done_pulse !== x.pulse) begin
            errors++;
            $display("FAIL %s: got cnt=%h done=%b run=%b pulse=%b, want cnt=%h done=%b run=%b pulse=%b",
                     x.name, obs, timer_done, running, done_pulse, x.cnt, x.done, x.run, x.pulse);
        end
        rst = 1'b0; key_valid = 1'b0; key_digit = 4'd0; mag_on = 1'b0;
    endtask

    task automatic test_key_entry();
        exp_t x;
        logic [3:0] digs [3] = '{4'd1, 4'd2, 4'd3};
        do_reset();
        sb.push_back(mk(0, "key_1", 16'h0001, 1'b0, 1'b0));
        sb.push_back(mk(0, "key_12", 16'h0012, 1'b0, 1'b0));
        sb.push_back(mk(0, "key_123", 16'h0123, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) begin
            press(digs[i]);
            x = sb.pop_front(); checks++;
            if (obs !== x.cnt || timer_done !== x.done || running !== x.run || done_pulse !== x.pulse) begin
                errors++;
                $display("FAIL %s: got cnt=%h done=%b run=%b pulse=%b, want cnt=%h done=%b run=%b pulse=%b",
                         x.name, obs, timer_done, running, done_pulse, x.cnt, x.done, x.run, x.pulse);
            end
        end
    endtask

    task automatic test_countdown();
        exp_t x;
        int p0;
        do_reset();
        press(4'd0); press(4'd0); press(4'd0); press(4'd2);
        sb.push_back(mk(1,  "run_entry",  16'h0002, 1'b1, 1'b0));
        sb.push_back(mk(4,  "pre_tick",   16'h0002, 1'b1, 1'b0));
        sb.push_back(mk(5,  "first_dec",  16'h0001, 1'b1, 1'b0));
        sb.push_back(mk(8,  "pre_done",   16'h0001, 1'b1, 1'b0));
        sb.push_back(mk(9,  "reach_zero", 16'h0000, 1'b0, 1'b1));
        sb.push_back(mk(10, "pulse_end",  16'h0000, 1'b0, 1'b0));
        p0 = pulse_cnt;
        mag_on = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (sb.size() > 0 && sb[0].cyc == e) begin
                x = sb.pop_front(); checks++;
                if (obs !== x.cnt || timer_done !== x.done || running !== x.run || done_pulse !== x.pulse) begin
                    errors++;
                    $display("FAIL %s: got cnt=%h done=%b run=%b pulse=%b, want cnt=%h done=%b run=%b pulse=%b",
                             x.name, obs, timer_done, running, done_pulse, x.cnt, x.done, x.run, x.pulse);
                end
            end
        end
        checks++;
        if (pulse_cnt - p0 !== 1) begin
            errors++;
            $display("FAIL done_pulse_count: got %0d, want 1", pulse_cnt - p0);
        end
        mag_on = 1'b0;
        key_valid = 1'b1; key_digit = 4'd7;
        step();
        key_valid = 1'b0; key_digit = 4'd0;
        sb.push_back(mk(0, "done_key_load", 16'h0007, 1'b0, 1'b0));
        x = sb.pop_front(); checks++;
        if (obs !== x.cnt || timer_done !== x.done || running !== x.run || done_pulse !== x.pulse) begin
            errors++;
            $display("FAIL %s: got cnt=%h done=%b run=%b pulse=%b, want cnt=%h done=%b run=%b pulse=%b",
                     x.name, obs, timer_done, running, done_pulse, x.cnt, x.done, x.run, x.pulse);
        end
    endtask

    task automatic test_pause();
        exp_t x;
        do_reset();
        press(4'd1); press(4'd0); press(4'd0);
        sb.push_back(mk(5,  "tick_dec",   16'h0059, 1'b1, 1'b0));
        sb.push_back(mk(15, "paused",     16'h0059, 1'b0, 1'b0));
        sb.push_back(mk(16, "resume",     16'h0059, 1'b1, 1'b0));
        sb.push_back(mk(18, "held_presc", 16'h0059, 1'b1, 1'b0));
        sb.push_back(mk(19, "resume_dec", 16'h0058, 1'b1, 1'b0));
        for (int e = 1; e <= 19; e++) begin
            mag_on    = !(e >= 6 && e <= 15);
            key_valid = (e == 10);
            key_digit = 4'd7;
            step();
            if (sb.size() > 0 && sb[0].cyc == e) begin
                x = sb.pop_front(); checks++;
                if (obs !== x.cnt || timer_done !== x.done || running !== x.run || done_pulse !== x.pulse) begin
                    errors++;
                    $display("FAIL %s: got cnt=%h done=%b run=%b pulse=%b, want cnt=%h done=%b run=%b pulse=%b",
                             x.name, obs, timer_done, running, done_pulse, x.cnt, x.done, x.run, x.pulse);
                end
            end
        end
        mag_on = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
    endtask

    task automatic test_zero_and_clear();
        exp_t x;
        int p0;
        do_reset();
        p0 = pulse_cnt;
        sb.push_back(mk(3, "zero_stays_idle", 16'h0000, 1'b0, 1'b0));
        mag_on = 1'b1;
        for (int e = 1; e <= 3; e++) step();
        x = sb.pop_front(); checks++;
        if (obs !== x.cnt || timer_done !== x.done || running !== x.run || done_pulse !== x.pulse) begin
            errors++;
            $display("FAIL %s: got cnt=%h done=%b run=%b pulse=%b, want cnt=%h done=%b run=%b pulse=%b",
                     x.name, obs, timer_done, running, done_pulse, x.cnt, x.done, x.run, x.pulse);
        end
        mag_on = 1'b0;
        press(4'd5);
        sb.push_back(mk(2,  "run_before_clear", 16'h0005, 1'b1, 1'b0));
        sb.push_back(mk(5,  "clear_mid_run",    16'h0000, 1'b0, 1'b0));
        sb.push_back(mk(10, "after_clear",      16'h0000, 1'b0, 1'b0));
        mag_on = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            clrn      = (e != 5);
            key_valid = (e == 5);
            key_digit = 4'd8;
            step();
            if (sb.size() > 0 && sb[0].cyc == e) begin
                x = sb.pop_front(); checks++;
                if (obs !== x.cnt || timer_done !== x.done || running !== x.run || done_pulse !== x.pulse) begin
                    errors++;
                    $display("FAIL %s: got cnt=%h done=%b run=%b pulse=%b, want cnt=%h done=%b run=%b pulse=%b",
                             x.name, obs, timer_done, running, done_pulse, x.cnt, x.done, x.run, x.pulse);
                end
            end
        end
        clrn = 1'b1; key_valid = 1'b0; key_digit = 4'd0; mag_on = 1'b0;
        checks++;
        if (pulse_cnt - p0 !== 0) begin
            errors++;
            $display("FAIL no_pulse_on_clear: got %0d pulses, want 0", pulse_cnt - p0);
        end
    endtask

    task automatic test_shift_and_invalid();
        exp_t x;
        do_reset();
        press(4'd9); press(4'd9); press(4'd9); press(4'd9); press(4'd5);
        sb.push_back(mk(0, "shift_out", 16'h9995, 1'b0, 1'b0));
        sb.push_back(mk(0, "invalid_digit", 16'h9995, 1'b0, 1'b0));
        x = sb.pop_front(); checks++;
        if (obs !== x.cnt || timer_done !== x.done || running !== x.run || done_pulse !== x.pulse) begin
            errors++;
            $display("FAIL %s: got cnt=%h done=%b run=%b pulse=%b, want cnt=%h done=%b run=%b pulse=%b",
                     x.name, obs, timer_done, running, done_pulse, x.cnt, x.done, x.run, x.pulse);
        end
        press(4'd12);
        x = sb.pop_front(); checks++;
        if (obs !== x.cnt || timer_done !== x.done || running !== x.run || done_pulse !== x.pulse) begin
            errors++;
            $display("FAIL %s: got cnt=%h done=%b run=%b pulse=%b, want cnt=%h done=%b run=%b pulse=%b",
                     x.name, obs, timer_done, running, done_pulse, x.cnt, x.done, x.run, x.pulse);
        end
    endtask

    task automatic test_add30();
        exp_t x;
        do_reset();
        press(4'd4); press(4'd5);
        add30 = 1'b1; step(); add30 = 1'b0;
`ifdef MICROWAVE_TIMER_ADD30_EN
        sb.push_back(mk(0, "add30_carry", 16'h0115, 1'b0, 1'b0));
        x = sb.pop_front(); checks++;
        if (obs !== x.cnt || timer_done !== x.done || running !== x.run || done_pulse !== x.pulse) begin
            errors++;
            $display("FAIL %s: got cnt=%h done=%b run=%b pulse=%b, want cnt=%h done=%b run=%b pulse=%b",
                     x.name, obs, timer_done, running, done_pulse, x.cnt, x.done, x.run, x.pulse);
        end
        do_reset();
        press(4'd9); press(4'd9); press(4'd4); press(4'd5);
        add30 = 1'b1; step(); add30 = 1'b0;
        sb.push_back(mk(0, "add30_saturate", 16'h9959, 1'b0, 1'b0));
        sb.push_back(mk(5, "done_for_add30", 16'h0000, 1'b0, 1'b1));
        sb.push_back(mk(0, "add30_in_done", 16'h0030, 1'b0, 1'b0));
        sb.push_back(mk(0, "idle_after_add30", 16'h0030, 1'b1, 1'b0));
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                do_reset();
                press(4'd1);
                mag_on = 1'b1;
                for (int e = 1; e <= 5; e++) step();
            end else if (i == 2) begin
                add30 = 1'b1; mag_on = 1'b0;
                step();
                add30 = 1'b0;
            end else if (i == 3) begin
                mag_on = 1'b1;
                step();
            end
            x = sb.pop_front(); checks++;
            if (obs !== x.cnt || timer_done !== x.done || running !== x.run || done_pulse !== x.pulse) begin
                errors++;
                $display("FAIL %s: got cnt=%h done=%b run=%b pulse=%b, want cnt=%h done=%b run=%b pulse=%b",
                         x.name, obs, timer_done, running, done_pulse, x.cnt, x.done, x.run, x.pulse);
            end
        end
        mag_on = 1'b0;
`else
        sb.push_back(mk(0, "add30_ignored", 16'h0045, 1'b0, 1'b0));
        x = sb.pop_front(); checks++;
        if (obs !== x.cnt || timer_done !== x.done || running !== x.run || done_pulse !== x.pulse) begin
            errors++;
            $display("FAIL %s: got cnt=%h done=%b run=%b pulse=%b, want cnt=%h done=%b run=%b pulse=%b",
                     x.name, obs, timer_done, running, done_pulse, x.cnt, x.done, x.run, x.pulse);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_key_entry();
        test_countdown();
        test_pause();
        test_zero_and_clear();
        test_shift_and_invalid();
        test_add30();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
